tdm_mux8to1: RTL and testbench

- Transmit-side 8:1 time-division multiplexer that is the counterpart of the team's 1:8 demux.
- Collects up to eight request/data channels and serialises them onto one data lane.
- Drives a 3-bit select code alongside the data, so a far-end demux with the same sel encoding can route each word back to its channel.
- Supports rotating-priority arbitration (skip idle channels) or fixed slot scanning, chosen by parameter.

---
 rtl/tdm_mux8to1_pkg.sv | 22 ++
 rtl/tdm_mux8to1_rr_arbiter8.sv | 13 +
 rtl/tdm_mux8to1.sv | 87 ++++++++
 tb/tb_tdm_mux8to1.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/tdm_mux8to1_pkg.sv
// rtl/tdm_mux8to1_pkg.sv - shared constants and rotating-priority pick function
package tdm_pkg;

    localparam int NCH  = 8;
    localparam int SELW = 3;

    // Returns {found, index} of the first requesting channel at or after ptr, wrapping mod 8
    function automatic logic [SELW:0] rr_pick(input logic [NCH-1:0] req, input logic [SELW-1:0] ptr);
        logic [SELW:0]   r;
        logic [SELW-1:0] i;
        r = '0;
        // Scan from the far end so the closest candidate to ptr is written last and wins
        for (int k = NCH - 1; k >= 0; k--) begin
            i = ptr + SELW'(k);
            if (req[i]) begin
                r = {1'b1, i};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tdm_mux8to1_rr_arbiter8.sv
// rtl/tdm_mux8to1_rr_arbiter8.sv - combinational rotating priority encoder
module rr_arbiter8
    import tdm_pkg::*;
(
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic            found,
    output logic [SELW-1:0] idx
);

    assign {found, idx} = rr_pick(req, ptr);

endmodule

// File: rtl/tdm_mux8to1.sv
// rtl/tdm_mux8to1.sv - 8:1 TDM transmit multiplexer with select code and frame marker
module tdm_mux8to1
    import tdm_pkg::*;
#(
    parameter int W         = 1,
    parameter bit SKIP_IDLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*W-1:0]  din,
    output logic [W-1:0]      out,
    output logic [SELW-1:0]   sel,
    output logic              valid,
    output logic [NCH-1:0]    gnt,
    output logic              frame
);

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] ptr_nxt;
    logic [SELW-1:0] idx;
    logic            hit;
    logic            upd_sel;
    logic            wrap;

    generate
        if (SKIP_IDLE) begin : g_rr
            logic            arb_found;
            logic [SELW-1:0] arb_idx;

            rr_arbiter8 u_arb (
                .req   (req),
                .ptr   (ptr),
                .found (arb_found),
                .idx   (arb_idx)
            );

            // Serve only requesting channels; the pointer parks just past the winner
            always_comb begin
                idx     = arb_idx;
                hit     = arb_found;
                upd_sel = arb_found;
                ptr_nxt = arb_found ? (arb_idx + SELW'(1)) : ptr;
            end
        end else begin : g_fixed
            // Visit every slot in turn; idle slots still advance the pointer and sel
            always_comb begin
                idx     = ptr;
                hit     = req[ptr];
                upd_sel = 1'b1;
                ptr_nxt = ptr + SELW'(1);
            end
        end
    endgenerate

    // The pointer wraps exactly when the slot being scheduled is channel 7
    assign wrap = upd_sel && (idx == SELW'(NCH - 1));

    // Scheduling pointer and registered output stage; pause keeps data/sel/ptr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            out   <= '0;
            sel   <= '0;
            valid <= 1'b0;
            gnt   <= '0;
            frame <= 1'b0;
        end else if (en) begin
            ptr   <= ptr_nxt;
            valid <= hit;
            gnt   <= hit ? (NCH'(1) << idx) : '0;
            frame <= wrap;
            if (upd_sel) begin
                sel <= idx;
            end
            if (hit) begin
                out <= din[idx*W +: W];
            end
        end else begin
            valid <= 1'b0;
            gnt   <= '0;
            frame <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tdm_mux8to1.sv
// tb/tb_tdm_mux8to1.sv - randomized and directed self-checking bench for tdm_mux8to1
module tb_tdm_mux8to1;

    localparam int W = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [7:0]    req;
    logic [8*W-1:0] din;

    logic [W-1:0]  out_rr, out_fx;
    logic [2:0]    sel_rr, sel_fx;
    logic          valid_rr, valid_fx;
    logic [7:0]    gnt_rr, gnt_fx;
    logic          frame_rr, frame_fx;

    int n_tests = 0;
    int n_fail  = 0;

    // model state, index 0 = round-robin instance, 1 = fixed-scan instance
    int m_ptr[2];
    int m_out[2];
    int m_sel[2];
    int m_valid[2];
    int m_gnt[2];
    int m_frame[2];

    int frames;
    int prev_sel;

    always #5 clk = ~clk;

    tdm_mux8to1 #(.W(W), .SKIP_IDLE(1'b1)) u_rr (
        .clk(clk), .rst(rst), .en(en), .req(req), .din(din),
        .out(out_rr), .sel(sel_rr), .valid(valid_rr), .gnt(gnt_rr), .frame(frame_rr)
    );

    tdm_mux8to1 #(.W(W), .SKIP_IDLE(1'b0)) u_fx (
        .clk(clk), .rst(rst), .en(en), .req(req), .din(din),
        .out(out_fx), .sel(sel_fx), .valid(valid_fx), .gnt(gnt_fx), .frame(frame_fx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_ptr[m] = 0; m_out[m] = 0; m_sel[m] = 0;
            m_valid[m] = 0; m_gnt[m] = 0; m_frame[m] = 0;
        end
    endtask

    task automatic model_step();
        int c;
        for (int m = 0; m < 2; m++) begin
            if (!en) begin
                m_valid[m] = 0; m_gnt[m] = 0; m_frame[m] = 0;
            end else if (m == 0) begin
                c = -1;
                for (int k = 0; k < 8; k++) begin
                    if (c < 0 && req[(m_ptr[0] + k) % 8]) c = (m_ptr[0] + k) % 8;
                end
                if (c >= 0) begin
                    m_out[0] = int'(din[c*W +: W]);
                    m_sel[0] = c; m_valid[0] = 1; m_gnt[0] = 1 << c;
                    m_frame[0] = (c == 7); m_ptr[0] = (c + 1) % 8;
                end else begin
                    m_valid[0] = 0; m_gnt[0] = 0; m_frame[0] = 0;
                end
            end else begin
                c = m_ptr[1];
                m_sel[1] = c;
                m_valid[1] = int'(req[c]);
                m_gnt[1] = req[c] ? (1 << c) : 0;
                if (req[c]) m_out[1] = int'(din[c*W +: W]);
                m_frame[1] = (c == 7);
                m_ptr[1] = (c + 1) % 8;
            end
        end
    endtask

    task automatic check_all();
        check("rr_out",   32'(out_rr),   32'(m_out[0]));
        check("rr_sel",   32'(sel_rr),   32'(m_sel[0]));
        check("rr_valid", 32'(valid_rr), 32'(m_valid[0]));
        check("rr_gnt",   32'(gnt_rr),   32'(m_gnt[0]));
        check("rr_frame", 32'(frame_rr), 32'(m_frame[0]));
        check("fx_out",   32'(out_fx),   32'(m_out[1]));
        check("fx_sel",   32'(sel_fx),   32'(m_sel[1]));
        check("fx_valid", 32'(valid_fx), 32'(m_valid[1]));
        check("fx_gnt",   32'(gnt_fx),   32'(m_gnt[1]));
        check("fx_frame", 32'(frame_fx), 32'(m_frame[1]));
    endtask

    // one clock: model follows the sampled inputs, outputs checked 1ns after the edge
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // asynchronous reset asserted between edges, checked before any clock edge
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = '0; din = '0;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        // run a little, then reset mid-operation with every channel requesting
        en = 1'b1; req = 8'hFF;
        for (int i = 0; i < 8; i++) din[i*W +: W] = W'(i + 3);
        step(); step(); step();
        do_reset();

        // full load: channel i carries bit (i odd)
        for (int i = 0; i < 8; i++) din[i*W +: W] = W'(i % 2);
        frames = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            check("full_sel", 32'(sel_rr), 32'(k % 8));
            check("full_out", 32'(out_rr), 32'(k % 2));
            check("full_onehot", 32'($onehot(gnt_rr)), 32'd1);
            frames += int'(frame_rr);
        end
        check("full_frames", 32'(frames), 32'd2);

        // sparse requests: 2 and 7 alternate with no idle slots
        req = 8'b1000_0100;
        step(); check("sparse_a", 32'({valid_rr, sel_rr}), 32'({1'b1, 3'd2}));
        step(); check("sparse_b", 32'({valid_rr, sel_rr}), 32'({1'b1, 3'd7}));
        step(); check("sparse_c", 32'({valid_rr, sel_rr}), 32'({1'b1, 3'd2}));

        // pause mid-rotation at sel 4, resume at 5
        req = 8'hFF;
        step(); step();
        check("pause_at4", 32'(sel_rr), 32'd4);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("pause_hold", 32'({valid_rr, gnt_rr, sel_rr}), 32'({1'b0, 8'h00, 3'd4}));
        end
        en = 1'b1;
        step(); check("resume_sel", 32'(sel_rr), 32'd5);

        // idle then a single late request on channel 3
        req = 8'h00;
        step(); step();
        check("idle_hold", 32'({valid_rr, gnt_rr, sel_rr}), 32'({1'b0, 8'h00, 3'd5}));
        req = 8'h08;
        step();
        check("late_req", 32'({valid_rr, gnt_rr, sel_rr}), 32'({1'b1, 8'h08, 3'd3}));

        // fixed scan: sel steps every cycle, valid only on slots 0 and 2
        req = 8'b0000_0101;
        frames = 0;
        prev_sel = int'(sel_fx);
        for (int k = 0; k < 16; k++) begin
            step();
            check("fx_scan_sel", 32'(sel_fx), 32'((prev_sel + 1) % 8));
            check("fx_scan_valid", 32'(valid_fx), 32'(sel_fx == 3'd0 || sel_fx == 3'd2));
            prev_sel = int'(sel_fx);
            frames += int'(frame_fx);
        end
        check("fx_frames", 32'(frames), 32'd2);

        // randomized traffic with occasional pauses and resets
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 1) == 0) req = 8'($urandom) & 8'($urandom);
            else req = 8'($urandom);
            din = 32'($urandom);
            en = ($urandom_range(0, 4) != 0);
            step();
            if ($urandom_range(0, 60) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
